// File: rtl/wb_demux.sv
// Write-back destination demultiplexer: routes an ALU result into the internal W register
// or out to the file register array through a req/ack handshake with timeout.
// Optional: define STATUS_Z_EN to add the z_flag output (zero status of each accepted result).
module wb_demux #(
    parameter int DW      = 8,
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sel,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] addr_in,
    output logic [DW-1:0] w_reg,
    output logic          w_we,
    output logic          f_req,
    output logic [AW-1:0] f_addr,
    output logic [DW-1:0] f_data,
    input  logic          f_ack,
`ifdef STATUS_Z_EN
    output logic          z_flag,
`endif
    output logic          done,
    output logic          err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Last F_WAIT count value: the counter would reach TIMEOUT on this edge.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        F_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic [DW-1:0] r_w_reg;
    logic [DW-1:0] w_w_reg_nxt;
    logic          r_w_we;
    logic          w_w_we_nxt;
    logic          r_f_req;
    logic          w_f_req_nxt;
    logic [AW-1:0] r_f_addr;
    logic [AW-1:0] w_f_addr_nxt;
    logic [DW-1:0] r_f_data;
    logic [DW-1:0] w_f_data_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic          w_accept;

`ifdef STATUS_Z_EN
    logic          r_z;
    logic          w_z_nxt;
`endif

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid && (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_w_reg  <= '0;
            r_w_we   <= 1'b0;
            r_f_req  <= 1'b0;
            r_f_addr <= '0;
            r_f_data <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_w_reg  <= w_w_reg_nxt;
            r_w_we   <= w_w_we_nxt;
            r_f_req  <= w_f_req_nxt;
            r_f_addr <= w_f_addr_nxt;
            r_f_data <= w_f_data_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_w_reg_nxt  = r_w_reg;
        w_w_we_nxt   = 1'b0;
        w_f_req_nxt  = r_f_req;
        w_f_addr_nxt = r_f_addr;
        w_f_data_nxt = r_f_data;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!sel) begin
                        w_w_reg_nxt = data_in;
                        w_w_we_nxt  = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_f_addr_nxt = addr_in;
                        w_f_data_nxt = data_in;
                        w_f_req_nxt  = 1'b1;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = F_WAIT;
                    end
                end
            end
            F_WAIT: begin
                // An ack on the timeout edge still completes the write.
                if (f_ack) begin
                    w_f_req_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_f_req_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_f_req_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef STATUS_Z_EN
    always_comb begin
        w_z_nxt = r_z;
        if (w_accept) begin
            w_z_nxt = (data_in == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z <= 1'b0;
        end else begin
            r_z <= w_z_nxt;
        end
    end

    assign z_flag = r_z;
`endif

    assign w_reg  = r_w_reg;
    assign w_we   = r_w_we;
    assign f_req  = r_f_req;
    assign f_addr = r_f_addr;
    assign f_data = r_f_data;
    assign done   = r_done;
    assign err    = r_err;

endmodule

// File: tb/tb_wb_demux.sv
// Bench for wb_demux: directed scenarios then randomized transactions against a
// transaction-level model that predicts the outcome edge from the ack delay.
module tb_wb_demux;

    localparam int DW      = 8;
    localparam int AW      = 5;
    localparam int TIMEOUT = 15;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          sel;
    logic [DW-1:0] data_in;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] w_reg;
    logic          w_we;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_data;
    logic          f_ack;
    logic          done;
    logic          err;
`ifdef STATUS_Z_EN
    logic          z_flag;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_w;
    logic          m_z;

    wb_demux #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .data_in  (data_in),
        .addr_in  (addr_in),
        .w_reg    (w_reg),
        .w_we     (w_we),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_data   (f_data),
        .f_ack    (f_ack),
`ifdef STATUS_Z_EN
        .z_flag   (z_flag),
`endif
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_z(input string tag);
`ifdef STATUS_Z_EN
        chkb(tag, z_flag, m_z);
`else
        if (tag.len() == 0) $display("unused tag");
`endif
    endtask

    // Called just after a clock edge; returns just after the outcome edge.
    task automatic txn(input logic s, input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input int ackdly, input bit poke);
        int  outc;
        bit  is_done;
        chkb("rdy_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        sel      = s;
        data_in  = d;
        addr_in  = a;
        f_ack    = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        f_ack    = 1'b0;
        data_in  = 8'($urandom);
        addr_in  = 5'($urandom);
        sel      = 1'($urandom);
        m_z      = (d == '0);
        if (!s) begin
            m_w = d;
            chkv("w_reg_after_w", 32'(w_reg), 32'(m_w));
            chkb("w_we_after_w", w_we, 1'b1);
            chkb("done_after_w", done, 1'b1);
            chkb("err_after_w", err, 1'b0);
            chkb("f_req_after_w", f_req, 1'b0);
            chkb("rdy_after_w", in_ready, 1'b1);
            chk_z("z_after_w");
        end else begin
            chkb("f_req_accept", f_req, 1'b1);
            chkv("f_addr_accept", 32'(f_addr), 32'(a));
            chkv("f_data_accept", 32'(f_data), 32'(d));
            chkb("rdy_accept", in_ready, 1'b0);
            chkb("done_accept", done, 1'b0);
            chkb("w_we_accept", w_we, 1'b0);
            chkv("w_reg_accept", 32'(w_reg), 32'(m_w));
            chk_z("z_accept");
            is_done = (ackdly < TIMEOUT);
            outc    = is_done ? ackdly + 1 : TIMEOUT;
            for (int n = 0; n < outc; n++) begin
                f_ack = (n >= ackdly);
                if (poke) begin
                    in_valid = 1'($urandom_range(0, 1));
                    sel      = 1'b0;
                    data_in  = 8'($urandom);
                end
                @(posedge clk); #1;
                if (n + 1 < outc) begin
                    chkb("f_req_busy", f_req, 1'b1);
                    chkv("f_addr_busy", 32'(f_addr), 32'(a));
                    chkv("f_data_busy", 32'(f_data), 32'(d));
                    chkb("done_busy", done, 1'b0);
                    chkb("err_busy", err, 1'b0);
                    chkb("rdy_busy", in_ready, 1'b0);
                    chkb("w_we_busy", w_we, 1'b0);
                end
            end
            in_valid = 1'b0;
            f_ack    = 1'b0;
            chkb("done_outcome", done, is_done);
            chkb("err_outcome", err, !is_done);
            chkb("f_req_outcome", f_req, 1'b0);
            chkb("rdy_outcome", in_ready, 1'b1);
            chkb("w_we_outcome", w_we, 1'b0);
            chkv("w_reg_outcome", 32'(w_reg), 32'(m_w));
            chk_z("z_outcome");
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sel      = 1'b0;
        data_in  = '0;
        addr_in  = '0;
        f_ack    = 1'b0;
        m_w      = '0;
        m_z      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chkv("rst_w_reg", 32'(w_reg), 32'(m_w));
        chkb("rst_f_req", f_req, 1'b0);
        chkb("rst_in_ready", in_ready, 1'b1);
        chkb("rst_done", done, 1'b0);
        chkb("rst_err", err, 1'b0);
        chkb("rst_w_we", w_we, 1'b0);
        chkv("rst_f_addr", 32'(f_addr), 32'h0);
        chkv("rst_f_data", 32'(f_data), 32'h0);
        chk_z("rst_z");

        // Back-to-back W writes, then the done/w_we pulses must drop.
        txn(1'b0, 8'hA5, 5'h00, 0, 1'b0);
        txn(1'b0, 8'h3C, 5'h00, 0, 1'b0);
        @(posedge clk); #1;
        chkb("done_pulse_end", done, 1'b0);
        chkb("w_we_pulse_end", w_we, 1'b0);
        chkv("w_reg_hold", 32'(w_reg), 32'h3C);

        // File write acked after 3 cycles, fastest ack, ack on the timeout edge, timeout.
        txn(1'b1, 8'h5A, 5'h07, 3, 1'b0);
        txn(1'b1, 8'h11, 5'h1F, 0, 1'b0);
        txn(1'b1, 8'h22, 5'h01, TIMEOUT - 1, 1'b0);
        txn(1'b1, 8'h44, 5'h02, TIMEOUT, 1'b0);
        @(posedge clk); #1;
        chkb("err_pulse_end", err, 1'b0);
        chkb("done_after_timeout", done, 1'b0);

`ifdef STATUS_Z_EN
        txn(1'b0, 8'h00, 5'h00, 0, 1'b0);
        txn(1'b1, 8'h12, 5'h03, 1, 1'b0);
`endif

        // W write attempted while busy, then asynchronous reset mid-transaction.
        in_valid = 1'b1; sel = 1'b1; data_in = 8'h33; addr_in = 5'h1E;
        @(posedge clk); #1;
        chkb("f_req_pre_rst", f_req, 1'b1);
        in_valid = 1'b1; sel = 1'b0; data_in = 8'hFF; f_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkv("w_ignored_busy", 32'(w_reg), 32'(m_w));
        chkb("rdy_busy_rst", in_ready, 1'b0);
        chkb("w_we_busy_rst", w_we, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        m_w = '0;
        m_z = 1'b0;
        chkb("async_f_req", f_req, 1'b0);
        chkv("async_w_reg", 32'(w_reg), 32'h0);
        chkb("async_rdy", in_ready, 1'b1);
        chkb("async_done", done, 1'b0);
        chkb("async_err", err, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chkb("post_rst_f_req", f_req, 1'b0);
        chkb("post_rst_done", done, 1'b0);
        chkv("post_rst_w_reg", 32'(w_reg), 32'h0);

        for (int i = 0; i < 40; i++) begin
            logic          rs;
            logic [DW-1:0] rd;
            rs = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            txn(rs, rd, 5'($urandom), $urandom_range(0, TIMEOUT + 2), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
                chkb("idle_done", done, 1'b0);
                chkb("idle_err", err, 1'b0);
                chkv("idle_w_reg", 32'(w_reg), 32'(m_w));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
